// File: rtl/pcie_wr_commit_pkg.sv
// pcie_wr_commit_pkg: PU header layouts, commit entry type and the commit Cpl builder
package pcie_wr_commit_pkg;

    localparam logic [7:0] FMT_CPL      = 8'h0A;
    localparam logic [7:0] FMT_MWR_MASK = 8'h5F;
    localparam logic [7:0] FMT_MWR_VAL  = 8'h40;

    typedef enum logic {IDLE, IN_WR} t_cap_state;

    typedef struct packed {
        logic [112:0] rsvd_hi;
        logic         vf_active;
        logic [10:0]  vf_num;
        logic [2:0]   pf_num;
        logic [63:0]  addr;
        logic [15:0]  req_id;
        logic [7:0]   tag_l;
        logic [7:0]   be;
        logic [7:0]   fmt_type;
        logic         tag_h;
        logic [2:0]   tc;
        logic         tag_m;
        logic [8:0]   attr_th;
        logic [9:0]   length;
    } t_pu_req_hdr;

    typedef struct packed {
        logic [112:0] rsvd_hi;
        logic         vf_active;
        logic [10:0]  vf_num;
        logic [2:0]   pf_num;
        logic [31:0]  rsvd_lo;
        logic [15:0]  req_id;
        logic [7:0]   tag_l;
        logic         rsvd_la;
        logic [6:0]   lower_addr;
        logic [15:0]  comp_id;
        logic [2:0]   status;
        logic         bcm;
        logic [11:0]  byte_count;
        logic [7:0]   fmt_type;
        logic         tag_h;
        logic [2:0]   tc;
        logic         tag_m;
        logic [8:0]   attr_th;
        logic [9:0]   length;
    } t_pu_cpl_hdr;

    typedef struct packed {
        logic [9:0]  tag;
        logic [15:0] req_id;
        logic [2:0]  pf_num;
        logic [10:0] vf_num;
        logic        vf_active;
    } t_commit_entry;

    // Status SC, completer id, length and byte count are all zero.
    function automatic t_pu_cpl_hdr build_cpl_hdr(input t_commit_entry e);
        t_pu_cpl_hdr h;
        h           = '0;
        h.fmt_type  = FMT_CPL;
        h.tag_h     = e.tag[9];
        h.tag_m     = e.tag[8];
        h.tag_l     = e.tag[7:0];
        h.req_id    = e.req_id;
        h.pf_num    = e.pf_num;
        h.vf_num    = e.vf_num;
        h.vf_active = e.vf_active;
        return h;
    endfunction

endpackage

// File: rtl/pcie_wr_commit_fifo.sv
// pcie_wr_commit_fifo: show-ahead register FIFO of commit entries with occupancy count
module pcie_wr_commit_fifo
    import pcie_wr_commit_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  t_commit_entry              wdata,
    input  logic                       pop,
    output t_commit_entry              rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    t_commit_entry mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (count != FULL_CNT || do_pop);
    assign drop    = push && !do_push;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pcie_wr_commit_gen.sv
// pcie_wr_commit_gen: emits one data-less Cpl on RX B per completed TX A MemWr; WR_COMMIT_STATS_EN adds stats
module pcie_wr_commit_gen
    import pcie_wr_commit_pkg::*;
#(
    parameter int TDATA_W    = 512,
    parameter int TUSER_W    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_tvalid,
    input  logic                          a_tready,
    input  logic                          a_tlast,
    input  logic [TDATA_W-1:0]            a_tdata,
    input  logic [TUSER_W-1:0]            a_tuser,
    output logic                          a_stall,
    output logic                          b_tvalid,
    input  logic                          b_tready,
    output logic [TDATA_W-1:0]            b_tdata,
    output logic [TDATA_W/8-1:0]          b_tkeep,
    output logic [TUSER_W-1:0]            b_tuser,
    output logic                          b_tlast,
    output logic                          err_ovf
`ifdef WR_COMMIT_STATS_EN
    ,
    output logic [31:0]                   stat_commits,
    output logic [$clog2(FIFO_DEPTH):0]   stat_max_occ
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH);

    t_pu_req_hdr   hdr;
    t_cap_state    state, state_nxt;
    t_commit_entry cur_ent, held_ent, push_ent, head;
    logic          beat, sop, is_wr, push, pop, empty, drop, unused_ok;
    logic [CW:0]   count;

    assign hdr       = t_pu_req_hdr'(a_tdata[255:0]);
    assign unused_ok = ^{a_tdata, a_tuser, hdr};
    assign beat      = a_tvalid && a_tready;
    assign is_wr     = sop && !a_tuser[0] && ((hdr.fmt_type & FMT_MWR_MASK) == FMT_MWR_VAL);
    assign cur_ent   = '{tag: {hdr.tag_h, hdr.tag_m, hdr.tag_l}, req_id: hdr.req_id,
                         pf_num: hdr.pf_num, vf_num: hdr.vf_num, vf_active: hdr.vf_active};

    // A single-beat write pushes straight from IDLE using the live header.
    always_comb begin
        push      = beat && a_tlast && (state == IN_WR || is_wr);
        push_ent  = state == IN_WR ? held_ent : cur_ent;
        state_nxt = !beat ? state : a_tlast ? IDLE : is_wr ? IN_WR : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sop      <= 1'b1;
            held_ent <= '0;
            a_stall  <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sop      <= beat ? a_tlast : sop;
            held_ent <= beat && is_wr ? cur_ent : held_ent;
            a_stall  <= count >= (CW+1)'(FIFO_DEPTH - 2);
            err_ovf  <= err_ovf | drop;
        end
    end

    pcie_wr_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .empty (empty),
        .drop  (drop)
    );

    assign pop      = b_tvalid && b_tready;
    assign b_tvalid = !empty;
    assign b_tdata  = b_tvalid ? TDATA_W'(build_cpl_hdr(head)) : '0;
    assign b_tkeep  = (TDATA_W/8)'({32{1'b1}});
    assign b_tuser  = '0;
    assign b_tlast  = b_tvalid;

`ifdef WR_COMMIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_commits <= '0;
            stat_max_occ <= '0;
        end else begin
            stat_commits <= stat_commits + 32'(pop);
            stat_max_occ <= count > stat_max_occ ? count : stat_max_occ;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_wr_commit_gen.sv
// tb_pcie_wr_commit_gen: directed stimulus checked every cycle against a queue model of the commit stream
module tb_pcie_wr_commit_gen;
    localparam int TW = 512;
    localparam int UW = 10;
    localparam int D  = 16;

    typedef struct {
        logic [9:0]  tag;
        logic [15:0] rid;
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vfa;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_tvalid, a_tready, a_tlast, a_stall, b_tvalid, b_tready, b_tlast, err_ovf;
    logic [TW-1:0]   a_tdata, b_tdata;
    logic [UW-1:0]   a_tuser, b_tuser;
    logic [TW/8-1:0] b_tkeep;
`ifdef WR_COMMIT_STATS_EN
    logic [31:0] stat_commits;
    logic [4:0]  stat_max_occ;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    logic m_err = 1'b0;
    logic m_stall = 1'b0;
    logic cur_is_wr = 1'b0;
    ent_t cur_ent;

    always #5 clk = ~clk;

    pcie_wr_commit_gen #(.TDATA_W(TW), .TUSER_W(UW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tlast(a_tlast),
        .a_tdata(a_tdata), .a_tuser(a_tuser), .a_stall(a_stall),
        .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata),
        .b_tkeep(b_tkeep), .b_tuser(b_tuser), .b_tlast(b_tlast),
        .err_ovf(err_ovf)
`ifdef WR_COMMIT_STATS_EN
        , .stat_commits(stat_commits), .stat_max_occ(stat_max_occ)
`endif
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", n, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [9:0] tag, input logic [15:0] rid,
                                input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
        ent_t e;
        e.tag = tag; e.rid = rid; e.pf = pf; e.vf = vf; e.vfa = vfa;
        return e;
    endfunction

    function automatic logic [TW-1:0] req_hdr(input logic [7:0] fmt, input ent_t e);
        logic [TW-1:0] h;
        h = '0;
        h[9:0]     = 10'd16;
        h[31:24]   = fmt;
        h[23]      = e.tag[9];
        h[19]      = e.tag[8];
        h[47:40]   = e.tag[7:0];
        h[63:48]   = e.rid;
        h[127:64]  = 64'h0000_DEAD_0000_1000;
        h[130:128] = e.pf;
        h[141:131] = e.vf;
        h[142]     = e.vfa;
        return h;
    endfunction

    function automatic logic [9:0] cpl_tag(input logic [TW-1:0] d);
        return {d[23], d[19], d[79:72]};
    endfunction

    // wr is the hand-stated expectation of whether this packet must produce a commit
    task automatic send(input logic [7:0] fmt, input logic dm, input ent_t e,
                        input int n, input bit stall_last, input bit wr);
        cur_ent   = e;
        cur_is_wr = wr;
        for (int i = 0; i < n; i++) begin
            a_tvalid = 1'b1;
            a_tlast  = (i == n - 1);
            a_tdata  = (i == 0) ? req_hdr(fmt, e) : {16{$urandom()}};
            a_tuser  = {9'h0, dm};
            if (stall_last && i == n - 1) begin
                a_tready = 1'b0;
                @(posedge clk); #1;
                a_tready = 1'b1;
            end
            @(posedge clk); #1;
        end
        a_tvalid  = 1'b0;
        a_tlast   = 1'b0;
        cur_is_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Model: commits in write order, capacity D, pop when ready, stall from pre-edge occupancy.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_err   = 1'b0;
            m_stall = 1'b0;
        end else begin
            automatic bit pop = mq.size() > 0 && b_tready;
            automatic bit ok  = mq.size() < D || pop;
            m_stall = mq.size() >= D - 2;
            if (pop) void'(mq.pop_front());
            if (a_tvalid && a_tready && a_tlast && cur_is_wr) begin
                if (ok) mq.push_back(cur_ent);
                else m_err = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("b_tvalid", b_tvalid, mq.size() != 0);
            chk("a_stall", a_stall, m_stall);
            chk("err_ovf", err_ovf, m_err);
            if (b_tvalid && mq.size() != 0) begin
                chk("tag", cpl_tag(b_tdata), mq[0].tag);
                chk("req_id", b_tdata[95:80], mq[0].rid);
                chk("pf", b_tdata[130:128], mq[0].pf);
                chk("vf", b_tdata[141:131], mq[0].vf);
                chk("vfa", b_tdata[142], mq[0].vfa);
                chk("fmt", b_tdata[31:24], 8'h0A);
                chk("len_bc_st_cid", {b_tdata[63:32], b_tdata[9:0]}, 0);
                chk("upper_zero", b_tdata[TW-1:143] == 0, 1);
                chk("tlast_tuser", {b_tlast, b_tuser}, {1'b1, 10'h0});
                chk("tkeep", b_tkeep, 64'h0000_0000_FFFF_FFFF);
            end
        end
    end

    initial begin
        a_tvalid = 1'b0; a_tready = 1'b1; a_tlast = 1'b0;
        a_tdata = '0; a_tuser = '0; b_tready = 1'b1;
        cur_ent = mk(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;
        chk("rst_b_tvalid", b_tvalid, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_b_tdata", b_tdata == 0, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'h60, 1'b0, mk(10'h2A5, 16'h1234, 3'd1, 11'd3, 1'b1), 1, 0, 1);
        @(negedge clk);
        chk("t1_valid", b_tvalid, 1);
        chk("t1_fmt", b_tdata[31:24], 8'h0A);
        chk("t1_tag", cpl_tag(b_tdata), 10'h2A5);
        chk("t1_pfvf", b_tdata[142:128], {1'b1, 11'd3, 3'd1});
        chk("t1_tlast", b_tlast, 1);
        @(negedge clk);
        chk("t1_empty", b_tvalid, 0);

        send(8'h60, 1'b0, mk(10'h011, 16'h0100, 3'd2, 11'd0, 1'b0), 4, 1, 1);
        @(negedge clk);
        chk("t2_valid", b_tvalid, 1);
        chk("t2_tag", cpl_tag(b_tdata), 10'h011);
        send(8'h20, 1'b0, mk(10'h012, 16'h0100, 3'd2, 11'd0, 1'b0), 1, 0, 0);
        send(8'h60, 1'b1, mk(10'h013, 16'h0100, 3'd2, 11'd0, 1'b0), 2, 0, 0);
        repeat (3) @(negedge clk);
        chk("t2_no_more", b_tvalid, 0);

        b_tready = 1'b0;
        for (int i = 0; i < 14; i++) send(8'h40, 1'b0, mk(10'(i), 16'h0200, 3'd0, 11'(i), 1'b1), 1, 0, 1);
        chk("t3_stall_lo", a_stall, 0);
        @(posedge clk); #1;
        chk("t3_stall_hi", a_stall, 1);
        chk("t3_head", cpl_tag(b_tdata), 10'h000);
        b_tready = 1'b1;
        repeat (14) @(posedge clk); #1;
        chk("t3_drained", b_tvalid, 0);
        chk("t3_no_ovf", err_ovf, 0);

        do_reset();
        b_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send(8'h60, 1'b0, mk(10'(100 + i), 16'h0300, 3'd4, 11'd7, 1'b0), 1, 0, 1);
            if (i == 15) chk("t4_ovf_lo", err_ovf, 0);
        end
        chk("t4_ovf_hi", err_ovf, 1);
        chk("t4_head", cpl_tag(b_tdata), 10'd100);
        b_tready = 1'b1;
        repeat (16) @(posedge clk); #1;
        chk("t4_drained", b_tvalid, 0);

        do_reset();
        b_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h60, 1'b0, mk(10'(200 + i), 16'h0400, 3'd5, 11'd9, 1'b1), 1, 0, 1);
        b_tready = 1'b1;
        send(8'h60, 1'b0, mk(10'h3FF, 16'h0401, 3'd6, 11'd10, 1'b1), 1, 0, 1);
        chk("t5_no_ovf", err_ovf, 0);
        repeat (15) @(posedge clk); #1;
        chk("t5_last_valid", b_tvalid, 1);
        chk("t5_last_tag", cpl_tag(b_tdata), 10'h3FF);
        @(posedge clk); #1;
        chk("t5_drained", b_tvalid, 0);

        b_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h60, 1'b0, mk(10'(300 + i), 16'h0500, 3'd3, 11'd1, 1'b0), 1, 0, 1);
        cur_ent   = mk(10'h3F0, 16'h0600, 3'd7, 11'd2, 1'b1);
        cur_is_wr = 1'b1;
        a_tvalid  = 1'b1;
        a_tlast   = 1'b0;
        a_tdata   = req_hdr(8'h60, cur_ent);
        a_tuser   = '0;
        @(posedge clk); #1;
        a_tdata = {16{$urandom()}};
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", b_tvalid, 0);
        chk("t6_rst_tdata", b_tdata == 0, 1);
`ifdef WR_COMMIT_STATS_EN
        chk("t6_stat_commits", stat_commits, 0);
`endif
        a_tvalid  = 1'b0;
        cur_is_wr = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        b_tready = 1'b1;
        send(8'h60, 1'b0, mk(10'h155, 16'h0700, 3'd1, 11'd5, 1'b1), 1, 0, 1);
        @(negedge clk);
        chk("t6_new_tag", cpl_tag(b_tdata), 10'h155);
        @(negedge clk);
        chk("t6_no_stale", b_tvalid, 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
